// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one registered adder between two valid/ready requesters.
// Optional feature macro: ADDER_ARB_ILLEGAL_CHECK_EN (answer mode 2'b11 with an error, no issue).
module adder_arbiter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [1:0]       req0_f_i,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    output logic             rsp0_valid_o,
    output logic [WIDTH-1:0] rsp0_y_o,
    output logic             rsp0_err_o,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [1:0]       req1_f_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    output logic             rsp1_valid_o,
    output logic [WIDTH-1:0] rsp1_y_o,
    output logic             rsp1_err_o,

    output logic [1:0]       add_f_o,
    output logic [WIDTH-1:0] add_a_o,
    output logic [WIDTH-1:0] add_b_o,
    input  logic [WIDTH-1:0] add_y_i
);

    localparam int unsigned CntW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCapt
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              prio_q, prio_d;
    logic              owner_q, owner_d;
    logic              illegal_q, illegal_d;
    logic [1:0]        add_f_q, add_f_d;
    logic [WIDTH-1:0]  add_a_q, add_a_d;
    logic [WIDTH-1:0]  add_b_q, add_b_d;

    logic [1:0]        grant;
    logic              accept;
    logic              win_id;
    logic [1:0]        win_f;
    logic [WIDTH-1:0]  win_a;
    logic [WIDTH-1:0]  win_b;
    logic              win_illegal;
    logic [1:0]        rsp_hit;

    logic [1:0]        rsp_valid_q;
    logic [1:0]        rsp_err_q;
    logic [WIDTH-1:0]  rsp0_y_q;
    logic [WIDTH-1:0]  rsp1_y_q;

    // Ready doubles as the grant; it is held low while reset is asserted.
    always_comb begin
        grant = 2'b00;
        if (rst && state_q == StIdle) begin
            if (req0_valid_i && (!req1_valid_i || !prio_q)) begin
                grant[0] = 1'b1;
            end else if (req1_valid_i) begin
                grant[1] = 1'b1;
            end
        end
    end

    assign accept = |grant;
    assign win_id = grant[1];
    assign win_f  = win_id ? req1_f_i : req0_f_i;
    assign win_a  = win_id ? req1_a_i : req0_a_i;
    assign win_b  = win_id ? req1_b_i : req0_b_i;

`ifdef ADDER_ARB_ILLEGAL_CHECK_EN
    assign win_illegal = (win_f == 2'b11);
`else
    assign win_illegal = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prio_d    = prio_q;
        owner_d   = owner_q;
        illegal_d = illegal_q;
        add_f_d   = add_f_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    prio_d    = ~prio_q;
                    owner_d   = win_id;
                    illegal_d = win_illegal;
                    if (win_illegal) begin
                        state_d = StCapt;
                    end else begin
                        add_f_d = win_f;
                        add_a_d = win_a;
                        add_b_d = win_b;
                        cnt_d   = CntW'(LATENCY);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StCapt;
                end
            end
            StCapt: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            illegal_q <= 1'b0;
            add_f_q   <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prio_q    <= prio_d;
            owner_q   <= owner_d;
            illegal_q <= illegal_d;
            add_f_q   <= add_f_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
        end
    end

    assign rsp_hit[0] = (state_q == StCapt) && !owner_q;
    assign rsp_hit[1] = (state_q == StCapt) &&  owner_q;

    // Results hold until the same requester's next response overwrites them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 2'b00;
            rsp0_y_q    <= '0;
            rsp1_y_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_hit;
            if (rsp_hit[0]) begin
                rsp0_y_q     <= illegal_q ? '0 : add_y_i;
                rsp_err_q[0] <= illegal_q;
            end
            if (rsp_hit[1]) begin
                rsp1_y_q     <= illegal_q ? '0 : add_y_i;
                rsp_err_q[1] <= illegal_q;
            end
        end
    end

    assign req0_ready_o = grant[0];
    assign req1_ready_o = grant[1];
    assign rsp0_valid_o = rsp_valid_q[0];
    assign rsp1_valid_o = rsp_valid_q[1];
    assign rsp0_y_o     = rsp0_y_q;
    assign rsp1_y_o     = rsp1_y_q;
    assign rsp0_err_o   = rsp_err_q[0];
    assign rsp1_err_o   = rsp_err_q[1];
    assign add_f_o      = add_f_q;
    assign add_a_o      = add_a_q;
    assign add_b_o      = add_b_q;

`ifndef SYNTHESIS
    a_one_ready : assert property (@(posedge clk) disable iff (!rst)
        !(req0_ready_o && req1_ready_o));
    a_operands_hold : assert property (@(posedge clk) disable iff (!rst)
        !accept |=> $stable({add_f_o, add_a_o, add_b_o}));
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized self-checking bench for adder_arbiter with a registered adder stand-in.
`timescale 1ns/1ps
module tb_adder_arbiter;

    localparam int unsigned W   = 4;
    localparam int unsigned LAT = 2;

    typedef struct packed {
        logic [1:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rst_next;
    logic         req0_valid, req0_ready, rsp0_valid, rsp0_err;
    logic         req1_valid, req1_ready, rsp1_valid, rsp1_err;
    logic [1:0]   req0_f, req1_f, add_f;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b, rsp0_y, rsp1_y;
    logic [W-1:0] add_a, add_b, add_y;
    logic [W-1:0] pipe [LAT];
    op_t          add_op;

    adder_arbiter #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_f_i     (req0_f),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .rsp0_valid_o (rsp0_valid),
        .rsp0_y_o     (rsp0_y),
        .rsp0_err_o   (rsp0_err),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_f_i     (req1_f),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .rsp1_valid_o (rsp1_valid),
        .rsp1_y_o     (rsp1_y),
        .rsp1_err_o   (rsp1_err),
        .add_f_o      (add_f),
        .add_a_o      (add_a),
        .add_b_o      (add_b),
        .add_y_i      (add_y)
    );

    always #5 clk = ~clk;

    // Adder arithmetic by mode; mode 2'b11 yields a^b as a recognisable stand-in.
    function automatic logic [W-1:0] add_ref(input op_t op);
        logic [W:0] s;
        s = {1'b0, op.a} + {1'b0, op.b};
        case (op.f)
            2'b01:   add_ref = s[W-1:0] + W'(s[W]);
            2'b11:   add_ref = op.a ^ op.b;
            default: add_ref = s[W-1:0];
        endcase
    endfunction

    function automatic op_t mk(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        op_t o;
        o.f = f;
        o.a = a;
        o.b = b;
        return o;
    endfunction

    assign add_op = {add_f, add_a, add_b};
    assign add_y  = pipe[LAT-1];

    always_ff @(posedge clk) begin
        pipe[0] <= add_ref(add_op);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: pending queues per requester, one op in flight.
    op_t          q0[$];
    op_t          q1[$];
    int unsigned  busy, p_cnt;
    bit           pending, p_ch, p_err, prio;
    logic [W-1:0] p_y;
    bit [1:0]     exp_v, exp_err;
    logic [W-1:0] exp_y [2];
    op_t          exp_op;

    task automatic model_reset();
        busy = 0;
        p_cnt = 0;
        pending = 0;
        prio = 0;
        exp_v = 2'b00;
        exp_err = 2'b00;
        exp_y[0] = '0;
        exp_y[1] = '0;
        exp_op = '0;
    endtask

    task automatic cycle();
        bit          v0, v1, g0, g1, ill;
        logic [31:0] rnd;
        op_t         op;
        @(negedge clk);
        rst = rst_next;
        v0 = (q0.size() != 0);
        v1 = (q1.size() != 0);
        rnd = $urandom;
        req0_valid = v0;
        {req0_f, req0_a, req0_b} = v0 ? q0[0] : op_t'(rnd[2*W+1:0]);
        rnd = $urandom;
        req1_valid = v1;
        {req1_f, req1_a, req1_b} = v1 ? q1[0] : op_t'(rnd[2*W+1:0]);
        #1;
        if (!rst) model_reset();
        g0 = 0;
        g1 = 0;
        if (rst && busy == 0) begin
            g0 = v0 && (!v1 || !prio);
            g1 = v1 && !g0;
        end
        check_eq("ready0", req0_ready, g0);
        check_eq("ready1", req1_ready, g1);
        check_eq("one_ready", req0_ready & req1_ready, 0);
        check_eq("rsp0_valid", rsp0_valid, exp_v[0]);
        check_eq("rsp1_valid", rsp1_valid, exp_v[1]);
        check_eq("rsp0_y", rsp0_y, exp_y[0]);
        check_eq("rsp1_y", rsp1_y, exp_y[1]);
        if (exp_v[0]) check_eq("rsp0_err", rsp0_err, exp_err[0]);
        if (exp_v[1]) check_eq("rsp1_err", rsp1_err, exp_err[1]);
        check_eq("add_f", add_f, exp_op.f);
        check_eq("add_a", add_a, exp_op.a);
        check_eq("add_b", add_b, exp_op.b);
        if (rst) begin
            exp_v = 2'b00;
            if (pending) begin
                if (p_cnt == 1) begin
                    exp_v[p_ch] = 1'b1;
                    exp_y[p_ch] = p_y;
                    exp_err[p_ch] = p_err;
                    pending = 0;
                end else begin
                    p_cnt--;
                end
            end
            if (busy != 0) busy--;
            if (g0 || g1) begin
                op = g0 ? q0.pop_front() : q1.pop_front();
                prio = !prio;
                pending = 1;
                p_ch = g1;
`ifdef ADDER_ARB_ILLEGAL_CHECK_EN
                ill = (op.f == 2'b11);
`else
                ill = 0;
`endif
                if (ill) begin
                    busy = 1;
                    p_cnt = 1;
                    p_y = '0;
                    p_err = 1;
                end else begin
                    busy = LAT + 1;
                    p_cnt = LAT + 1;
                    p_y = add_ref(op);
                    p_err = 0;
                    exp_op = op;
                end
            end
        end
    endtask

    initial begin
        rst_next = 1'b0;
        req0_valid = 0; req0_f = '0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_f = '0; req1_a = '0; req1_b = '0;
        model_reset();
        #1 rst = 1'b0;

        // Request waits through reset, then goes first.
        q0.push_back(mk(2'b00, 4'hF, 4'h1));
        repeat (3) cycle();
        rst_next = 1'b1;
        repeat (8) cycle();

        q1.push_back(mk(2'b01, 4'hF, 4'h1));
        repeat (8) cycle();

        repeat (4) begin
            q0.push_back(mk(2'b10, 4'hF, 4'h1));
            q1.push_back(mk(2'b00, 4'h3, 4'h4));
        end
        repeat (45) cycle();

        // Reset while the operation is in the adder.
        q0.push_back(mk(2'b00, 4'h5, 4'h6));
        cycle();
        cycle();
        rst_next = 1'b0;
        q0.push_back(mk(2'b01, 4'h9, 4'h9));
        repeat (3) cycle();
        q1.push_back(mk(2'b10, 4'h2, 4'h7));
        rst_next = 1'b1;
        repeat (12) cycle();

        q0.push_back(mk(2'b11, 4'hF, 4'h1));
        repeat (8) cycle();

        repeat (600) begin
            if (q0.size() < 2 && $urandom_range(0, 3) == 0)
                q0.push_back(op_t'($urandom_range(0, (1 << (2 * W + 2)) - 1)));
            if (q1.size() < 2 && $urandom_range(0, 3) == 0)
                q1.push_back(op_t'($urandom_range(0, (1 << (2 * W + 2)) - 1)));
            cycle();
        end
        repeat (20) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

- Shares one registered `adder` datapath between two requesters, each with its own valid/ready request channel.
- Arbitrates round-robin and drives the adder's mode and operands from internal registers.
- Waits out the adder's pipeline latency, then returns the result to the winning requester as a one-cycle response pulse.
- Sits between the adder and its two clients; it is the only block that drives the adder inputs.

## Interface

Parameters:
- `WIDTH`, 4, operand/result width; must match the adder.
- `LATENCY`, 1, adder input-to-`y` latency in clock edges; must be ≥1.

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req0_valid_i`  in  1  requester 0 has an operation
- `req0_ready_o`  out  1  requester 0 granted; transfer on valid&ready at rising edge
- `req0_f_i`  in  2  requester 0 mode
- `req0_a_i`, `req0_b_i`  in  WIDTH  requester 0 operands
- `rsp0_valid_o`  out  1  one-cycle result pulse for requester 0
- `rsp0_y_o`  out  WIDTH  result for requester 0
- `rsp0_err_o`  out  1  illegal-mode flag, qualified by `rsp0_valid_o`
- `req1_*` / `rsp1_*`  same as requester 0, for requester 1
- `add_f_o`  out  2  to adder `f_i`
- `add_a_o`, `add_b_o`  out  WIDTH  to adder `a_i` / `b_i`
- `add_y_i`  in  WIDTH  from adder `y_o`

## Operation

Mode encodings:
- 2'b00 unsigned
- 2'b01 ones-complement
- 2'b10 twos-complement
- 2'b11 illegal

States:
- IDLE: accepting requests.
- WAIT: operation in the adder; `cnt` counts down from `LATENCY`.
- CAPT: `add_y_i` holds the result.

Transitions:
- IDLE → WAIT on an accept. Load `add_f_o`/`add_a_o`/`add_b_o` from the winner, record the winner id, set `cnt=LATENCY`.
- WAIT: decrement `cnt` each cycle. → CAPT when `cnt==1` at the edge.
- CAPT → IDLE. At this edge, register `add_y_i` into `rspN_y_o` of the recorded winner and set `rspN_valid_o=1` for exactly one cycle.

Arbitration:
- Ready is asserted only in IDLE.
- Sole valid requester wins.
- When both are valid, the requester selected by `prio` wins.
- `prio` flips to the other requester after every accept. Reset value of `prio` is requester 0.
- `reqN_ready_o` may depend combinationally on both `reqX_valid_i`. At most one `ready` is high per cycle.

Operand hold:
- `add_*_o` stay stable from the accept edge until the next accept.
- Operands are never changed while in WAIT/CAPT.
- `rspN_y_o` holds its value until overwritten by that requester's next response.

Widths: `add_y_i` is passed through unmodified at WIDTH bits. No carry or overflow reporting.

## Timing

- Accept at edge E0. `rspN_valid_o` is high in the cycle after edge E(LATENCY+1). For LATENCY=1, that is 2 cycles after accept.
- Ready is asserted again in the same cycle as the response pulse. A new accept there gives throughput of one op per LATENCY+2 cycles.
- Requester holds `valid`/`f`/`a`/`b` until accepted. Inputs are sampled only at the accept edge.
- `rst` low: asynchronously force the following, and drop any in-flight operation with no response:
  - state IDLE, `prio`=0, `cnt`=0
  - all `rsp*_valid_o`, `rsp*_y_o`, `rsp*_err_o` = 0
  - `add_f_o`/`add_a_o`/`add_b_o` = 0
  - `req*_ready_o` = 0 while `rst` is low
- First accept is possible at the first rising edge after `rst` deasserts.

## Configuration

Macro `ADDER_ARB_ILLEGAL_CHECK_EN`.

Defined:
- A request with `f`=2'b11 is accepted but not issued to the adder; `add_*_o` are unchanged.
- FSM goes IDLE → CAPT directly.
- Response pulses one cycle later than a normal op would start it (cycle after E1) with `rspN_y_o`=0 and `rspN_err_o`=1.
- `prio` still flips.

Not defined:
- 2'b11 is issued like any other mode and the adder's result is returned.
- `rsp*_err_o` is tied to 0.

## Test plan

- Reset, `req0` f=00, a=4'b1111, b=4'b0001 → `req0_ready_o`=1 at accept; `rsp0_valid_o` one cycle, 2 cycles later, `rsp0_y_o`=4'b0000.
- `req1` f=01, a=1111, b=0001 → `rsp1_y_o`=4'b0001; `rsp0_valid_o` stays 0.
- Both valid every cycle (req0 f=10 a=1111 b=0001, req1 f=00 a=0011 b=0100) → grants alternate 0,1,0,1; responses `y`=0000 and 0111 on the matching channel; never both ready.
- `rst` pulled low in WAIT → no response pulse after release; all outputs 0; next grant goes to requester 0.
- With `ADDER_ARB_ILLEGAL_CHECK_EN`, `req0` f=11 → `add_*_o` unchanged; `rsp0_valid_o`=1 and `rsp0_err_o`=1 with `y`=0 at cycle after E1.
- Without the macro, same stimulus → `rsp0_err_o`=0, result returned after the normal latency.
